// File: rtl/soft_rst_ctrl.sv
// rtl/soft_rst_ctrl.sv - soft-reset sequencer: min-width assertion, ordered PCS/RX/TX release
module soft_rst_ctrl #(
    parameter int P_ASSERT_CYC = 16,
    parameter int P_GAP_CYC    = 8
) (
    input  logic       i_cfg_clk,
    input  logic       i_cfg_rst,
    input  logic       i_pcs_rst_req,
    input  logic       i_tx_rst_req,
    input  logic       i_rx_rst_req,
    input  logic       i_auto_rst_en,
    input  logic       i_link_fail,
    output logic       o_soft_pcs_rst_n,
    output logic       o_soft_tx_rst_n,
    output logic       o_soft_rx_rst_n,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rst_cnt
);
    localparam int CW = $clog2((P_ASSERT_CYC > P_GAP_CYC) ? P_ASSERT_CYC : P_GAP_CYC) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(P_ASSERT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(P_GAP_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP_RX, S_GAP_TX} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    mode_q, mode_d;
    logic [2:0]    pend_q, pend_d;
    logic          lf_q, lf_d;
    logic          pwrup_q, pwrup_d;
    logic          pcs_n_q, pcs_n_d, rx_n_q, rx_n_d, tx_n_q, tx_n_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [7:0]    rst_cnt_q, rst_cnt_d;
    logic [2:0]    req, start_mask;
    logic          finish;

    always_comb begin
        // Masks are {pcs, rx, tx}; any PCS request widens to the full sequence.
        req        = {i_pcs_rst_req, i_rx_rst_req | (i_auto_rst_en & i_link_fail & ~lf_q), i_tx_rst_req};
        start_mask = req | pend_q;
        if (start_mask[2]) start_mask = 3'b111;

        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        mode_d    = mode_q;
        pend_d    = pend_q;
        lf_d      = i_link_fail;
        pwrup_d   = pwrup_q;
        pcs_n_d   = pcs_n_q;
        rx_n_d    = rx_n_q;
        tx_n_d    = tx_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rst_cnt_d = rst_cnt_q;
        finish    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                // The o_done cycle still reports busy, so its requests only queue.
                if (busy_q) begin
                    pend_d = pend_q | req;
                end else if (start_mask != 3'b000) begin
                    state_d = S_HOLD;
                    mode_d  = start_mask;
                    pend_d  = '0;
                    busy_d  = 1'b1;
                    pcs_n_d = ~start_mask[2];
                    rx_n_d  = ~start_mask[1];
                    tx_n_d  = ~start_mask[0];
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (mode_q[2]) begin
                        pcs_n_d = 1'b1;
                        state_d = S_GAP_RX;
                    end else if (mode_q == 3'b011) begin
                        rx_n_d  = 1'b1;
                        state_d = S_GAP_TX;
                    end else begin
                        rx_n_d = 1'b1;
                        tx_n_d = 1'b1;
                        finish = 1'b1;
                    end
                end
            end
            S_GAP_RX: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    rx_n_d  = 1'b1;
                    state_d = S_GAP_TX;
                end
            end
            default: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d  = '0;
                    tx_n_d = 1'b1;
                    finish = 1'b1;
                end
            end
        endcase

        if (state_q != S_IDLE) pend_d = pend_q | req;

        if (finish) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            pwrup_d = 1'b0;
            if (!pwrup_q && rst_cnt_q != 8'hFF) rst_cnt_d = rst_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_cfg_clk) begin
        if (i_cfg_rst) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            mode_q    <= 3'b111;
            pend_q    <= '0;
            lf_q      <= 1'b0;
            pwrup_q   <= 1'b1;
            pcs_n_q   <= 1'b0;
            rx_n_q    <= 1'b0;
            tx_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            rst_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            lf_q      <= lf_d;
            pwrup_q   <= pwrup_d;
            pcs_n_q   <= pcs_n_d;
            rx_n_q    <= rx_n_d;
            tx_n_q    <= tx_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign o_soft_pcs_rst_n = pcs_n_q;
    assign o_soft_rx_rst_n  = rx_n_q;
    assign o_soft_tx_rst_n  = tx_n_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_rst_cnt        = rst_cnt_q;
endmodule

// File: doc/soft_rst_ctrl.md
# soft_rst_ctrl

Soft-reset sequencer in the configuration clock domain. It converts single-cycle reset requests from the register block, plus an optional link-fail trigger, into the three active-low soft resets `c_soft_pcs_rst_n`, `c_soft_tx_rst_n` and `c_soft_rx_rst_n` consumed by the clock/reset block. That block ANDs them with power-on reset and synchronises the result into each datapath clock. This block guarantees a minimum assertion width and an ordered release: PCS first, then RX, then TX.

## Interface
- `P_ASSERT_CYC`, default 16: cycles a requested reset is held low; must be ≥2.
- `P_GAP_CYC`, default 8: cycles between successive releases; must be ≥1.
- `i_cfg_clk`  in  1  configuration clock; the only clock.
- `i_cfg_rst`  in  1  reset, synchronous, active-high.
- `i_pcs_rst_req`  in  1  one-cycle pulse; requests a full PCS+RX+TX reset.
- `i_tx_rst_req`  in  1  one-cycle pulse; requests a TX-only reset.
- `i_rx_rst_req`  in  1  one-cycle pulse; requests an RX-only reset.
- `i_auto_rst_en`  in  1  enables the link-fail trigger.
- `i_link_fail`  in  1  level input, already synchronous to `i_cfg_clk`.
- `o_soft_pcs_rst_n`  out  1  drives `c_soft_pcs_rst_n`.
- `o_soft_tx_rst_n`  out  1  drives `c_soft_tx_rst_n`.
- `o_soft_rx_rst_n`  out  1  drives `c_soft_rx_rst_n`.
- `o_busy`  out  1  high while a sequence is in progress.
- `o_done`  out  1  one-cycle pulse in the final-release cycle.
- `o_rst_cnt`  out  8  number of completed requested sequences; saturates at 255.

## Operation
- **Outputs are registered.** All outputs are flops.
- **Request mask.** Each request is a 3-bit mask {pcs, rx, tx}.
  - A PCS request, alone or combined with any other request, selects the full sequence.
  - TX and RX requests in the same cycle select the {rx, tx} sequence.
- **Link-fail trigger.** A rising edge of `i_link_fail` while `i_auto_rst_en`=1 is treated as an RX request.
  - Edge detection uses a registered copy of `i_link_fail`.
  - A held-high level triggers exactly once.
- **FSM states:** IDLE, HOLD, GAP_RX, GAP_TX.
- **IDLE.**
  - All `rst_n` outputs are 1 and `o_busy`=0.
  - A nonzero request mask or pending mask moves to HOLD and clears the counter.
  - The outputs in the mask go to 0 in that same transition.
- **HOLD.** Lasts `P_ASSERT_CYC` cycles. On exit:
  - Full sequence: release PCS, go to GAP_RX.
  - {rx, tx} sequence: release RX, go to GAP_TX.
  - Single-domain sequence: release that domain, pulse `o_done`, go to IDLE.
- **GAP_RX.** Lasts `P_GAP_CYC` cycles, then releases RX and goes to GAP_TX.
- **GAP_TX.** Lasts `P_GAP_CYC` cycles, then releases TX, pulses `o_done` and goes to IDLE.
- **Requests while busy.**
  - Requests that arrive while `o_busy`=1, including in the `o_done` cycle, are OR-ed into a pending mask.
  - The pending mask is consumed and cleared on the IDLE→HOLD transition.
  - Requests are never dropped, but are merged.
- **`o_rst_cnt`.** Increments by 1 on each `o_done`, except for the power-up sequence. Saturates at 255.
- **Power-up.** Reset loads state HOLD with mode=full and counter 0.
  - After `i_cfg_rst` falls, the full release sequence runs automatically.
  - `o_done` pulses at its end; `o_rst_cnt` does not increment.

## Timing
- **Reset values.**
  - `o_soft_pcs_rst_n`, `o_soft_tx_rst_n`, `o_soft_rx_rst_n` = 0.
  - `o_busy` = 1, `o_done` = 0, `o_rst_cnt` = 0.
  - Pending mask and link-fail history = 0.
- **Request latency.** For a request sampled at edge N (in IDLE):
  - Masked outputs are 0 from cycle N+1.
  - First release at N+1+A, where A = `P_ASSERT_CYC`.
  - Second release at N+1+A+G, where G = `P_GAP_CYC`.
  - Third release at N+1+A+2G.
- **`o_busy`** is 1 from N+1 through the final-release cycle inclusive.
- **`o_done`** coincides with the final release.
- **Pending start.** A pending mask starts its sequence with outputs low two cycles after `o_done`: one cycle in IDLE, then the drop.
- **Power-up timing.** Counting the first cycle with `i_cfg_rst`=0 as cycle 0: PCS=1 at A, RX=1 at A+G, TX=1 at A+2G.
- **Reset mid-sequence.** `i_cfg_rst` high at any edge forces reset values at the next cycle and discards pending requests. The power-up sequence then restarts.
- **Held-low domains.** A domain not in the active mask stays 1 throughout the sequence.

## Test plan
All scenarios use A=16, G=8.
1. **Power-up.** Deassert `i_cfg_rst` at cycle 0 → PCS=1 at 16, RX=1 at 24, TX=1 at 32; `o_done` at 32; `o_busy` low at 33; `o_rst_cnt`=0.
2. **TX-only.** `i_tx_rst_req` at edge 100 → TX low 101..116, high at 117; `o_done` at 117; PCS and RX stay 1; `o_rst_cnt`=1.
3. **Combined request, then pending request.**
   - PCS+TX pulse at 200 → all three low at 201; PCS=1 at 217, RX=1 at 225, TX=1 at 233.
   - `i_rx_rst_req` at 210 → RX low 235..250, high at 251; `o_rst_cnt` increments at 233 and at 251.
4. **Link-fail trigger.**
   - `i_link_fail` rises at 300 and stays high, with `i_auto_rst_en`=1 → exactly one RX sequence: RX low 301..316.
   - Same stimulus with `i_auto_rst_en`=0 → no change.
5. **Reset mid-sequence.** Assert `i_cfg_rst` at cycle 7 of a TX sequence → all `rst_n`=0 and `o_rst_cnt`=0 next cycle; after release, the power-up timing of scenario 1 repeats.
6. **Counter saturation.** Issue 260 TX requests → `o_rst_cnt` holds 255.
